// File: rtl/clock_display_driver.sv
// clock_display_driver
// Converts binary minutes/hours to BCD with a sequential double-dabble engine
// and drives a 4-digit multiplexed common-anode seven-segment display (HH:MM).
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for update (or a pending reload); digits stable
// S_SHIFT  | six add-3/shift steps on minutes and hours in parallel
// S_COMMIT | load all four digit registers at once, then reload or idle
module clock_display_driver #(
  parameter int SCAN_DIV   = 1000,
  parameter bit LEAD_BLANK = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_update,
  input  logic [5:0] i_min_in,
  input  logic [4:0] i_hour_in,
  output logic       o_busy,
  output logic [6:0] o_seg,
  output logic [3:0] o_an
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);

  // Digit register codes beyond 0-9
  localparam logic [3:0] DIG_DASH  = 4'hA;
  localparam logic [3:0] DIG_BLANK = 4'hF;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t      r_state;
  logic [13:0] r_min_sr;
  logic [13:0] r_hour_sr;
  logic [2:0]  r_cnt;
  logic        r_min_bad;
  logic        r_hour_bad;
  logic        r_pending;
  logic [5:0]  r_min_sh;
  logic [4:0]  r_hour_sh;
  logic        r_busy;

  logic [3:0]  r_dig0;
  logic [3:0]  r_dig1;
  logic [3:0]  r_dig2;
  logic [3:0]  r_dig3;

  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic [6:0]    r_seg;
  logic [3:0]    r_an;

  logic [5:0]  w_src_min;
  logic [4:0]  w_src_hour;
  logic        w_start;
  logic [1:0]  w_next_idx;
  logic [3:0]  w_next_dig;
  logic [6:0]  w_next_seg;

  // One double-dabble step: add 3 to any BCD nibble >= 5, then shift left.
  // Layout is {tens[3:0], units[3:0], binary[5:0]}.
  function automatic logic [13:0] dabble_step(input logic [13:0] v);
    logic [13:0] t;
    t = v;
    if (t[13:10] >= 4'd5) t[13:10] = t[13:10] + 4'd3;
    if (t[9:6]   >= 4'd5) t[9:6]   = t[9:6]   + 4'd3;
    return {t[12:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:     s = 7'b1000000;
      4'd1:     s = 7'b1111001;
      4'd2:     s = 7'b0100100;
      4'd3:     s = 7'b0110000;
      4'd4:     s = 7'b0011001;
      4'd5:     s = 7'b0010010;
      4'd6:     s = 7'b0000010;
      4'd7:     s = 7'b1111000;
      4'd8:     s = 7'b0000000;
      4'd9:     s = 7'b0010000;
      DIG_DASH: s = SEG_DASH;
      default:  s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // A fresh update wins over the shadow copy; otherwise reload from the shadow.
  always_comb begin
    w_start    = (r_state == S_IDLE) && (i_update || r_pending);
    w_src_min  = i_update ? i_min_in  : r_min_sh;
    w_src_hour = i_update ? i_hour_in : r_hour_sh;
  end

  // Conversion FSM: capture, six dabble steps, atomic commit of all digits.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= S_IDLE;
      r_min_sr   <= '0;
      r_hour_sr  <= '0;
      r_cnt      <= '0;
      r_min_bad  <= 1'b0;
      r_hour_bad <= 1'b0;
      r_pending  <= 1'b0;
      r_min_sh   <= '0;
      r_hour_sh  <= '0;
      r_busy     <= 1'b0;
      r_dig0     <= '0;
      r_dig1     <= '0;
      r_dig2     <= '0;
      r_dig3     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_min_sr   <= {8'd0, w_src_min};
            r_hour_sr  <= {8'd0, 1'b0, w_src_hour};
            r_min_bad  <= (w_src_min  > 6'd59);
            r_hour_bad <= (w_src_hour > 5'd23);
            r_cnt      <= '0;
            r_pending  <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_min_sr  <= dabble_step(r_min_sr);
          r_hour_sr <= dabble_step(r_hour_sr);
          r_cnt     <= r_cnt + 3'd1;
          if (r_cnt == 3'd5) r_state <= S_COMMIT;
          if (i_update) begin
            r_pending <= 1'b1;
            r_min_sh  <= i_min_in;
            r_hour_sh <= i_hour_in;
          end
        end
        S_COMMIT: begin
          r_dig0  <= r_min_bad  ? DIG_DASH : r_min_sr[9:6];
          r_dig1  <= r_min_bad  ? DIG_DASH : r_min_sr[13:10];
          r_dig2  <= r_hour_bad ? DIG_DASH : r_hour_sr[9:6];
          r_dig3  <= r_hour_bad ? DIG_DASH : r_hour_sr[13:10];
          // Busy stays high across the reload cycle when another value is queued.
          r_busy  <= r_pending | i_update;
          r_state <= S_IDLE;
          if (i_update) begin
            r_pending <= 1'b1;
            r_min_sh  <= i_min_in;
            r_hour_sh <= i_hour_in;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Select the digit that becomes visible at the next scan step.
  always_comb begin
    w_next_idx = r_idx + 2'd1;
    case (w_next_idx)
      2'd0:    w_next_dig = r_dig0;
      2'd1:    w_next_dig = r_dig1;
      2'd2:    w_next_dig = r_dig2;
      default: w_next_dig = r_dig3;
    endcase
    if ((w_next_idx == 2'd3) && (w_next_dig == 4'd0) && LEAD_BLANK)
      w_next_seg = seg_decode(DIG_BLANK);
    else
      w_next_seg = seg_decode(w_next_dig);
  end

  // Display scan: prescaler wrap advances the digit; an and seg move together.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_an    <= 4'b1110;
      r_seg   <= 7'b1000000;
    end else if (r_presc == PMAX) begin
      r_presc <= '0;
      r_idx   <= w_next_idx;
      r_an    <= ~(4'b0001 << w_next_idx);
      r_seg   <= w_next_seg;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  assign o_busy = r_busy;
  assign o_seg  = r_seg;
  assign o_an   = r_an;

endmodule

// File: tb/tb_clock_display_driver.sv
// Testbench for clock_display_driver: directed scenarios plus randomized
// conversions checked against an arithmetic model of the displayed time.
`timescale 1ns/1ps
module tb_clock_display_driver;

  localparam int SCAN_DIV = 10;

  logic       i_clk;
  logic       i_reset;
  logic       i_update;
  logic [5:0] i_min_in;
  logic [4:0] i_hour_in;
  logic       o_busy;
  logic [6:0] o_seg;
  logic [3:0] o_an;

  int n_checks = 0;
  int n_fails  = 0;
  int cur_m    = 0;
  int cur_h    = 0;

  clock_display_driver #(.SCAN_DIV(SCAN_DIV), .LEAD_BLANK(1'b1)) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_update  (i_update),
    .i_min_in  (i_min_in),
    .i_hour_in (i_hour_in),
    .o_busy    (o_busy),
    .o_seg     (o_seg),
    .o_an      (o_an)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [6:0] digit_seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected segments for a display position given the committed time.
  function automatic logic [6:0] model_seg(input int pos, input int m, input int h);
    int d;
    if (pos < 2) begin
      if (m > 59) return 7'b0111111;
      d = (pos == 0) ? (m % 10) : (m / 10);
    end else begin
      if (h > 23) return 7'b0111111;
      d = (pos == 2) ? (h % 10) : (h / 10);
      if (pos == 3 && d == 0) return 7'b1111111;
    end
    return digit_seg(d);
  endfunction

  // Wait for the next scan step, then observe four full digit periods.
  task automatic check_display(input string name, input int m, input int h);
    logic [3:0] prev;
    int idx, n, pos;
    bit changed;
    prev = o_an;
    changed = 0;
    for (int k = 0; k < 2 * SCAN_DIV + 2; k++) begin
      tick();
      if (o_an !== prev) begin
        changed = 1;
        break;
      end
    end
    n_checks++;
    if (!changed) begin
      n_fails++;
      $display("FAIL %s scan_stalled: an=%b did not change", name, o_an);
      return;
    end
    pos = -1;
    for (int i = 0; i < 4; i++) if (o_an == ~(4'b0001 << i)) pos = i;
    for (int step = 0; step < 4; step++) begin
      if (step > 0) pos = (pos + 1) % 4;
      n_checks++;
      if (pos < 0 || o_an !== ~(4'b0001 << pos)) begin
        n_fails++;
        $display("FAIL %s an_seq: got %b expected %b", name, o_an,
                 (pos < 0) ? 4'bxxxx : ~(4'b0001 << pos));
        return;
      end
      n_checks++;
      if (o_seg !== model_seg(pos, m, h)) begin
        n_fails++;
        $display("FAIL %s seg_pos%0d: got %b expected %b", name, pos, o_seg,
                 model_seg(pos, m, h));
      end
      prev = o_an;
      n = 0;
      while (o_an === prev && n < 3 * SCAN_DIV) begin
        tick();
        n++;
      end
      n_checks++;
      if (n != SCAN_DIV) begin
        n_fails++;
        $display("FAIL %s scan_period: got %0d cycles expected %0d", name, n, SCAN_DIV);
      end
    end
  endtask

  // Single update pulse; checks busy over the 7-cycle latency window.
  task automatic do_convert(input string name, input int m, input int h);
    int bad;
    i_min_in  = 6'(m);
    i_hour_in = 5'(h);
    i_update  = 1'b1;
    tick();
    i_update  = 1'b0;
    bad = 0;
    if (o_busy !== 1'b1) bad++;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (o_busy !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fails++;
      $display("FAIL %s busy_window: busy low in %0d of 7 cycles, expected 0", name, bad);
    end
    tick();
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_fails++;
      $display("FAIL %s busy_clear: got %b expected 0", name, o_busy);
    end
    cur_m = m;
    cur_h = h;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n;
    n = 0;
    while (o_busy !== 1'b0 && n < limit) begin
      tick();
      n++;
    end
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_fails++;
      $display("FAIL %s wait_idle: busy=%b after %0d cycles expected 0", name, o_busy, n);
    end
  endtask

  task automatic test_reset();
    i_reset   = 1'b0;
    i_update  = 1'b0;
    i_min_in  = '0;
    i_hour_in = '0;
    repeat (3) tick();
    i_reset = 1'b1;
    tick();
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_busy: got %b expected 0", o_busy);
    end
    n_checks++;
    if (o_an !== 4'b1110) begin
      n_fails++;
      $display("FAIL reset_an: got %b expected 1110", o_an);
    end
    n_checks++;
    if (o_seg !== 7'b1000000) begin
      n_fails++;
      $display("FAIL reset_seg: got %b expected 1000000", o_seg);
    end
    cur_m = 0;
    cur_h = 0;
    check_display("reset_scan", cur_m, cur_h);
  endtask

  task automatic test_basic();
    do_convert("basic_45_17", 45, 17);
    check_display("basic_45_17", cur_m, cur_h);
    do_convert("max_59_23", 59, 23);
    check_display("max_59_23", cur_m, cur_h);
    do_convert("zero", 0, 0);
    check_display("zero", cur_m, cur_h);
  endtask

  task automatic test_range();
    do_convert("range_60_24", 60, 24);
    check_display("range_60_24", cur_m, cur_h);
    do_convert("range_61_5", 61, 5);
    check_display("range_61_5", cur_m, cur_h);
  endtask

  task automatic test_back_to_back();
    int bad;
    i_min_in  = 6'd10;
    i_hour_in = 5'd10;
    i_update  = 1'b1;
    tick();
    i_update  = 1'b0;
    bad = (o_busy !== 1'b1) ? 1 : 0;
    tick();
    tick();
    i_min_in  = 6'd33;
    i_hour_in = 5'd13;
    i_update  = 1'b1;
    tick();
    i_update  = 1'b0;
    i_min_in  = 6'd2;
    i_hour_in = 5'd2;
    if (o_busy !== 1'b1) bad++;
    for (int k = 4; k <= 14; k++) begin
      tick();
      if (o_busy !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fails++;
      $display("FAIL b2b_busy_continuous: busy low in %0d cycles expected 0", bad);
    end
    tick();
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_fails++;
      $display("FAIL b2b_busy_clear_n15: got %b expected 0", o_busy);
    end
    cur_m = 33;
    cur_h = 13;
    check_display("b2b_final", cur_m, cur_h);
  endtask

  task automatic test_held_update();
    int bad;
    i_min_in  = 6'd28;
    i_hour_in = 5'd9;
    i_update  = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (o_busy !== 1'b1) bad++;
    end
    i_update = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_fails++;
      $display("FAIL held_busy: busy low in %0d cycles expected 0", bad);
    end
    wait_idle("held", 20);
    cur_m = 28;
    cur_h = 9;
    check_display("held", cur_m, cur_h);
  endtask

  task automatic test_reset_mid();
    int bad;
    i_min_in  = 6'd27;
    i_hour_in = 5'd8;
    i_update  = 1'b1;
    tick();
    i_update  = 1'b0;
    repeat (3) tick();
    i_reset = 1'b0;
    #1;
    n_checks++;
    if (o_busy !== 1'b0 || o_an !== 4'b1110 || o_seg !== 7'b1000000) begin
      n_fails++;
      $display("FAIL midreset_outputs: busy=%b an=%b seg=%b expected 0 1110 1000000",
               o_busy, o_an, o_seg);
    end
    repeat (2) tick();
    i_reset = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (o_busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fails++;
      $display("FAIL midreset_no_commit: busy high in %0d cycles expected 0", bad);
    end
    cur_m = 0;
    cur_h = 0;
    check_display("midreset", cur_m, cur_h);
  endtask

  task automatic test_random();
    int m, h;
    for (int it = 0; it < 15; it++) begin
      m = $urandom_range(0, 63);
      h = $urandom_range(0, 31);
      repeat ($urandom_range(0, 5)) tick();
      do_convert("random", m, h);
      check_display("random", cur_m, cur_h);
    end
  endtask

  initial begin
    i_reset   = 1'b0;
    i_update  = 1'b0;
    i_min_in  = '0;
    i_hour_in = '0;
    #3;
    test_reset();
    test_basic();
    test_range();
    test_back_to_back();
    test_held_update();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
